irq_prio_ctrl: RTL and testbench
================================

Name: irq_prio_ctrl

Overview:
- 8-source interrupt controller that sequences a highest-index-wins priority encoder.
- Captures rising edges on request lines into a pending register and applies a mask.
- Presents one winning ID at a time to a single consumer through a req/ack/eoi handshake.
- Sits between peripheral event lines and the core's single interrupt input.

Parameters:
- N, 8, number of interrupt sources.
- IDW, 3, ID width; equals $clog2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq  input  N  raw level request lines; a 0->1 transition marks a new event.
- mask  input  N  per-source enable; 1 = eligible.
- ack  input  1  consumer accepts the current int_id; single-cycle pulse.
- eoi  input  1  consumer finished servicing; single-cycle pulse.
- int_req  output  1  request to consumer.
- int_id  output  IDW  index of the highest set bit of the granted source.
- busy  output  1  high while in SERVICE.
- pending_o  output  N  current pending register, for status reads.

Behaviour:
- Reset (async, rst=1):
  - irq_q, pending = 0; state = IDLE.
  - int_req = 0, int_id = 0, busy = 0, pending_o = 0.
- Edge capture:
  - rise = irq & ~irq_q; irq_q <= irq every cycle.
  - pending <= (pending & ~clr) | rise.
  - clr is a one-hot of int_id, asserted only on the ack cycle.
  - rise on the same bit as clr in the same cycle: set wins, and the bit stays pending.
- Eligible = pending & mask.
- Winner = index of the highest set bit of eligible. No valid winner when eligible = 0.
- States:
  - IDLE: if eligible != 0, latch the winner into int_id and go to REQ. Otherwise stay.
  - REQ: int_req = 1; int_id frozen.
    - ack=1: clear pending[int_id], go to SERVICE, int_req = 0 on the next cycle.
    - Mask or pending changes do not retract or alter an issued request.
  - SERVICE: busy = 1; int_req = 0.
    - eoi=1: go to IDLE; int_id holds its last value.
    - New events keep accumulating in pending.
- No nesting: a higher-priority event arriving in REQ or SERVICE waits until IDLE.
- Latency:
  - irq goes high and is sampled at edge n; pending bit is set at edge n.
  - State enters REQ at edge n+1; int_req is visible after edge n+1.
  - Back-to-back: eoi at edge m, with eligible still nonzero, gives REQ at edge m+1.
- Ignored inputs:
  - ack outside REQ, and eoi outside SERVICE.
  - ack and eoi together in REQ: ack is honoured, eoi is dropped.
- Level-held irq generates exactly one event; it must fall and rise again to re-pend.
- Masked pending bits remain pending and become eligible once unmasked.
- Reset mid-operation (any state): immediate return to reset values; pending events are lost.

Decomposition:
- Package irq_pkg:
  - N_SRC = 8 and ID_W = 3.
  - State enum state_t {IDLE, REQ, SERVICE}, 2-bit encoding.
- Sub-module irq_prio_enc, combinational:
  - Inputs: eligible[N].
  - Outputs: id[IDW] = index of the highest set bit; valid = |eligible.
  - Instantiated once; id is 0 when valid = 0.

Test Plan:
- Reset then irq=8'h00, mask=8'hFF for 10 cycles -> int_req=0, int_id=0, busy=0, pending_o=0 throughout.
- irq rises to 8'h24, mask=8'hFF -> pending_o=8'h24 after one edge; int_req=1, int_id=5 after the next edge. ack -> pending_o=8'h04, busy=1. eoi -> int_req=1, int_id=2 one edge later.
- mask=8'h0F, irq rises to 8'h80 -> pending_o=8'h80, int_req stays 0. Set mask=8'hFF -> int_req=1, int_id=7 after the next edge.
- In REQ with int_id=3, pulse irq[3] low then high so it re-rises on the ack cycle -> pending_o[3]=1 after ack (set wins); int_id=3 requested again after eoi.
- In SERVICE, irq[6] rises; eoi ignored before then -> int_req=0 until eoi. After eoi -> int_id=6.
- Assert rst for 1 cycle while in REQ with pending_o=8'h11 -> int_req=0, pending_o=0, state IDLE immediately (asynchronous). No request until a new irq edge.

Source files
------------

// File: rtl/irq_prio_ctrl_pkg.sv
// Shared types and sizing for the 8-source priority interrupt controller.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the highest set index wins; id is 0 when nothing is set.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N   = N_SRC,
  parameter int IDW = ID_W
) (
  input  logic [N-1:0]   eligible,
  output logic [IDW-1:0] id,
  output logic           valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) id = IDW'(i);
    end
  end

  assign valid = |eligible;

endmodule

// File: rtl/irq_prio_ctrl.sv
// Edge-capturing interrupt controller that hands one winning ID at a time
// to a single consumer through a req/ack/eoi handshake.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int N   = N_SRC,
  parameter int IDW = ID_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq,
  input  logic [N-1:0]   mask,
  input  logic           ack,
  input  logic           eoi,
  output logic           int_req,
  output logic [IDW-1:0] int_id,
  output logic           busy,
  output logic [N-1:0]   pending_o
);

  state_t         state_q, state_d;
  logic [N-1:0]   irq_q, irq_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [IDW-1:0] int_id_q, int_id_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   clr;
  logic [N-1:0]   eligible;
  logic [IDW-1:0] win_id;
  logic           win_valid;

  assign rise     = irq & ~irq_q;
  assign eligible = pending_q & mask;

  irq_prio_enc #(
    .N   (N),
    .IDW (IDW)
  ) u_enc (
    .eligible (eligible),
    .id       (win_id),
    .valid    (win_valid)
  );

  // int_id is only updated on the IDLE->REQ step, so an issued request
  // cannot be altered by later mask or pending changes.
  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = REQ;
          int_id_d = win_id;
        end
      end
      REQ: begin
        if (ack) begin
          clr     = N'(1) << int_id_q;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new rising edge on the bit being acknowledged keeps it pending.
  always_comb begin
    irq_d     = irq;
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      int_id_q  <= int_id_d;
    end
  end

  assign int_req   = (state_q == REQ);
  assign busy      = (state_q == SERVICE);
  assign int_id    = int_id_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: a behavioural model predicts each cycle's
// status and every granted ID; a separate monitor compares what the DUT shows.
module tb_irq_prio_ctrl;

  localparam int NS = 8;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic          clk;
  logic          rst;
  logic [NS-1:0] irq;
  logic [NS-1:0] mask;
  logic          ack;
  logic          eoi;
  logic          int_req;
  logic [2:0]    int_id;
  logic          busy;
  logic [NS-1:0] pending_o;

  irq_prio_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .mask      (mask),
    .ack       (ack),
    .eoi       (eoi),
    .int_req   (int_req),
    .int_id    (int_id),
    .busy      (busy),
    .pending_o (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         req;
    int         id;
    bit         busy;
    logic [7:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];

  int compared;
  int mismatched;

  // Reference model state
  bit m_pend[NS];
  bit m_prev[NS];
  int m_mode;
  int m_id;

  task automatic cmp(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] i_irq, input logic [7:0] i_mask,
                            input logic i_ack, input logic i_eoi, input logic i_rst);
    int   winner;
    exp_t e;
    if (i_rst) begin
      for (int i = 0; i < NS; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
      end
      m_mode = M_IDLE;
      m_id   = 0;
    end else begin
      winner = -1;
      for (int i = 0; i < NS; i++)
        if (m_pend[i] && i_mask[i]) winner = i;
      if (m_mode == M_IDLE) begin
        if (winner >= 0) begin
          m_mode = M_REQ;
          m_id   = winner;
          grant_q.push_back(winner);
        end
      end else if (m_mode == M_REQ) begin
        if (i_ack) begin
          m_pend[m_id] = 0;
          m_mode = M_SVC;
        end
      end else begin
        if (i_eoi) m_mode = M_IDLE;
      end
      for (int i = 0; i < NS; i++) begin
        if (i_irq[i] && !m_prev[i]) m_pend[i] = 1;
        m_prev[i] = i_irq[i];
      end
    end
    e.req  = (m_mode == M_REQ);
    e.busy = (m_mode == M_SVC);
    e.id   = m_id;
    for (int i = 0; i < NS; i++) e.pend[i] = m_pend[i];
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive just after the monitor has sampled.
  task automatic applyStimulus(input logic [7:0] i_irq, input logic [7:0] i_mask,
                               input logic i_ack, input logic i_eoi, input logic i_rst);
    @(negedge clk);
    #1;
    irq  = i_irq;
    mask = i_mask;
    ack  = i_ack;
    eoi  = i_eoi;
    rst  = i_rst;
    model_step(i_irq, i_mask, i_ack, i_eoi, i_rst);
    if (i_rst) begin
      #1;
      cmp("async_rst_int_req", int'(int_req), 0);
      cmp("async_rst_busy", int'(busy), 0);
      cmp("async_rst_pending", int'(pending_o), 0);
      cmp("async_rst_int_id", int'(int_id), 0);
    end
  endtask

  task automatic idle(input logic [7:0] i_irq, input logic [7:0] i_mask, input int n);
    for (int k = 0; k < n; k++) applyStimulus(i_irq, i_mask, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle status compare and grant compare on each new request.
  initial begin : monitor
    exp_t e;
    int   g;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("int_req", int'(int_req), int'(e.req));
        cmp("busy", int'(busy), int'(e.busy));
        cmp("int_id", int'(int_id), e.id);
        cmp("pending_o", int'(pending_o), int'(e.pend));
      end
      if (int_req && !prev_req) begin
        if (grant_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL grant: unexpected request id=%0d, none expected", int_id);
        end else begin
          g = grant_q.pop_front();
          cmp("grant_id", int'(int_id), g);
        end
      end
      prev_req = int_req;
    end
  end

  initial begin : stimulus
    logic [7:0] r_irq;
    logic [7:0] r_mask;
    irq  = '0;
    mask = 8'hFF;
    ack  = 1'b0;
    eoi  = 1'b0;
    rst  = 1'b1;

    // Reset then quiet
    applyStimulus(8'h00, 8'hFF, 0, 0, 1);
    applyStimulus(8'h00, 8'hFF, 0, 0, 1);
    idle(8'h00, 8'hFF, 10);

    // Two sources, highest first, then back-to-back second grant
    idle(8'h24, 8'hFF, 2);
    applyStimulus(8'h24, 8'hFF, 1, 0, 0);
    applyStimulus(8'h24, 8'hFF, 0, 1, 0);
    idle(8'h24, 8'hFF, 1);
    applyStimulus(8'h24, 8'hFF, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1, 0);
    idle(8'h00, 8'hFF, 2);

    // Masked pending becomes eligible when unmasked
    idle(8'h00, 8'h0F, 1);
    idle(8'h80, 8'h0F, 3);
    idle(8'h80, 8'hFF, 1);
    applyStimulus(8'h80, 8'hFF, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1, 0);
    idle(8'h00, 8'hFF, 2);

    // Re-rise on the ack cycle keeps the bit pending
    idle(8'h08, 8'hFF, 2);
    applyStimulus(8'h00, 8'hFF, 0, 0, 0);
    applyStimulus(8'h08, 8'hFF, 1, 0, 0);
    applyStimulus(8'h08, 8'hFF, 0, 1, 0);
    idle(8'h08, 8'hFF, 1);
    applyStimulus(8'h08, 8'hFF, 1, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1, 0);
    idle(8'h00, 8'hFF, 2);

    // Higher-priority arrival during SERVICE waits; stray ack/eoi ignored
    idle(8'h01, 8'hFF, 1);
    applyStimulus(8'h01, 8'hFF, 0, 1, 0);
    applyStimulus(8'h01, 8'hFF, 1, 0, 0);
    applyStimulus(8'h41, 8'hFF, 1, 0, 0);
    idle(8'h41, 8'hFF, 2);
    applyStimulus(8'h41, 8'hFF, 0, 1, 0);
    idle(8'h41, 8'hFF, 1);
    applyStimulus(8'h41, 8'hFF, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1, 0);
    idle(8'h00, 8'hFF, 2);

    // Reset while in REQ with two pending sources
    idle(8'h11, 8'hFF, 2);
    applyStimulus(8'h00, 8'hFF, 0, 0, 1);
    idle(8'h00, 8'hFF, 5);

    // Randomized traffic
    r_irq  = 8'h00;
    r_mask = 8'hFF;
    for (int k = 0; k < 3000; k++) begin
      r_irq = r_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0)
        r_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      applyStimulus(r_irq, r_mask,
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 299) == 0));
    end
    idle(8'h00, 8'hFF, 1);

    repeat (3) @(negedge clk);
    #2;
    if (grant_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL grant_drain: %0d predicted grants never seen, expected 0", grant_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
